// File: rtl/fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl_pkg
// Description : Shared constants for the IF-stage fetch sequencing controller.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_ctrl_pkg;

    localparam int PC_W_DEFAULT = 8;
    localparam int FLUSH_CNT_W  = 3;

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_run    = 3'd1;
    localparam logic [2:0] c_st_stall  = 3'd2;
    localparam logic [2:0] c_st_flush  = 3'd3;
    localparam logic [2:0] c_st_halted = 3'd4;

endpackage
`default_nettype wire

// File: rtl/fetch_ctrl_flush_timer.sv
`default_nettype none
// ============================================================================
// Module      : flush_timer
// Description : Loadable down-counter with hold; stops at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module flush_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_hold,
    output logic [WIDTH-1:0] o_count,
    output logic             o_zero
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Load wins over hold so a new flush window always starts full.
    always_comb begin
        count_d = count_q;
        if (i_load) begin
            count_d = i_load_val;
        end else if (!i_hold && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;
    assign o_zero  = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : IF-stage sequencer arbitrating branch, stall and halt requests.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int PC_W         = PC_W_DEFAULT,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 8
) (
    input  logic             CLK,
    input  logic             Init,
    input  logic             BrReq,
    input  logic [PC_W-1:0]  BrTarget,
    input  logic             StallReq,
    input  logic             HaltInstr,
    input  logic             Resume,
    output logic             Branch,
    output logic [PC_W-1:0]  Target,
    output logic             Halt,
    output logic             Flush,
    output logic             Running,
    output logic [CNT_W-1:0] BranchCount
);

    localparam logic [FLUSH_CNT_W-1:0] c_flush_load = FLUSH_CNT_W'(FLUSH_CYCLES);

    logic [2:0]       state_q,       state_d;
    logic             branch_q,      branch_d;
    logic [PC_W-1:0]  target_q,      target_d;
    logic             halt_q,        halt_d;
    logic             flush_q,       flush_d;
    logic             running_q,     running_d;
    logic [CNT_W-1:0] count_q,       count_d;
    logic             pend_valid_q,  pend_valid_d;
    logic [PC_W-1:0]  pend_target_q, pend_target_d;

    logic                   w_issue;
    logic [PC_W-1:0]        w_issue_target;
    logic                   w_flush_stall;
    logic                   w_tmr_load;
    logic [FLUSH_CNT_W-1:0] w_tmr_count;
    logic                   w_tmr_zero;

    flush_timer #(
        .WIDTH (FLUSH_CNT_W)
    ) u_flush_timer (
        .clk        (CLK),
        .rst        (Init),
        .i_load     (w_tmr_load),
        .i_load_val (c_flush_load),
        .i_hold     (w_flush_stall),
        .o_count    (w_tmr_count),
        .o_zero     (w_tmr_zero)
    );

    always_comb begin
        state_d        = state_q;
        branch_d       = 1'b0;
        target_d       = target_q;
        flush_d        = 1'b0;
        count_d        = count_q;
        pend_valid_d   = pend_valid_q;
        pend_target_d  = pend_target_q;
        w_issue        = 1'b0;
        w_issue_target = BrTarget;
        w_flush_stall  = 1'b0;
        w_tmr_load     = 1'b0;

        case (state_q)
            c_st_idle: begin
                state_d = c_st_run;
            end
            c_st_run: begin
                if (HaltInstr) begin
                    state_d = c_st_halted;
                end else if (BrReq) begin
                    w_issue = 1'b1;
                end else if (StallReq) begin
                    state_d = c_st_stall;
                end
            end
            c_st_stall: begin
                if (HaltInstr) begin
                    state_d      = c_st_halted;
                    pend_valid_d = 1'b0;
                end else if (!StallReq) begin
                    // A fresh request on the release cycle is newer than the pending one.
                    if (BrReq) begin
                        w_issue = 1'b1;
                    end else if (pend_valid_q) begin
                        w_issue        = 1'b1;
                        w_issue_target = pend_target_q;
                    end else begin
                        state_d = c_st_run;
                    end
                end else if (BrReq) begin
                    pend_valid_d  = 1'b1;
                    pend_target_d = BrTarget;
                end
            end
            c_st_flush: begin
                if (StallReq) begin
                    w_flush_stall = 1'b1;
                    flush_d       = 1'b1;
                end else if (w_tmr_zero || (w_tmr_count == FLUSH_CNT_W'(1))) begin
                    state_d = c_st_run;
                end else begin
                    flush_d = 1'b1;
                end
            end
            c_st_halted: begin
                if (Resume) begin
                    state_d = c_st_run;
                end
            end
            default: begin
                state_d = c_st_idle;
            end
        endcase

        if (w_issue) begin
            state_d      = c_st_flush;
            branch_d     = 1'b1;
            target_d     = w_issue_target;
            flush_d      = 1'b1;
            pend_valid_d = 1'b0;
            w_tmr_load   = 1'b1;
            count_d      = (count_q == '1) ? count_q : count_q + CNT_W'(1);
        end

        running_d = (state_d == c_st_run) || (state_d == c_st_flush);
        halt_d    = !((state_d == c_st_run) || ((state_d == c_st_flush) && !w_flush_stall));
    end

    always_ff @(posedge CLK) begin
        if (Init) begin
            state_q       <= c_st_idle;
            branch_q      <= 1'b0;
            target_q      <= '0;
            halt_q        <= 1'b1;
            flush_q       <= 1'b0;
            running_q     <= 1'b0;
            count_q       <= '0;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
        end else begin
            state_q       <= state_d;
            branch_q      <= branch_d;
            target_q      <= target_d;
            halt_q        <= halt_d;
            flush_q       <= flush_d;
            running_q     <= running_d;
            count_q       <= count_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign Branch      = branch_q;
    assign Target      = target_q;
    assign Halt        = halt_q;
    assign Flush       = flush_q;
    assign Running     = running_q;
    assign BranchCount = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Directed vector bench for fetch_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

    typedef struct {
        logic       init;
        logic       br;
        logic [7:0] tgt;
        logic       stall;
        logic       hi;
        logic       res;
        logic       e_br;
        logic [7:0] e_tgt;
        logic       e_halt;
        logic       e_flush;
        logic       e_run;
        logic [7:0] e_cnt;
    } vec_t;

    logic       clk = 1'b0;
    logic       init = 1'b1;
    logic       br_req = 1'b0;
    logic [7:0] br_tgt = 8'd0;
    logic       stall = 1'b0;
    logic       halt_in = 1'b0;
    logic       resume = 1'b0;
    logic       branch;
    logic [7:0] target;
    logic       halt;
    logic       flush;
    logic       running;
    logic [7:0] bcount;

    int   checks = 0;
    int   errors = 0;
    logic prev_branch = 1'b0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .CLK         (clk),
        .Init        (init),
        .BrReq       (br_req),
        .BrTarget    (br_tgt),
        .StallReq    (stall),
        .HaltInstr   (halt_in),
        .Resume      (resume),
        .Branch      (branch),
        .Target      (target),
        .Halt        (halt),
        .Flush       (flush),
        .Running     (running),
        .BranchCount (bcount)
    );

    task automatic add(input logic i, input logic b, input logic [7:0] t, input logic s,
                       input logic h, input logic r, input logic eb, input logic [7:0] et,
                       input logic eh, input logic ef, input logic er, input logic [7:0] ec);
        vec_t v;
        v.init = i; v.br = b; v.tgt = t; v.stall = s; v.hi = h; v.res = r;
        v.e_br = eb; v.e_tgt = et; v.e_halt = eh; v.e_flush = ef; v.e_run = er; v.e_cnt = ec;
        vecs.push_back(v);
    endtask

    // Drives one cycle of inputs, then checks the branch invariants after the edge.
    task automatic step(input logic i, input logic b, input logic [7:0] t, input logic s,
                        input logic h, input logic r);
        @(negedge clk);
        init = i; br_req = b; br_tgt = t; stall = s; halt_in = h; resume = r;
        @(posedge clk);
        #1;
        checks++;
        if (branch && (halt || !flush || prev_branch)) begin
            errors++;
            $display("FAIL invariant: Branch=%0b Halt=%0b Flush=%0b prevBranch=%0b, required Halt=0 Flush=1 prevBranch=0",
                     branch, halt, flush, prev_branch);
        end
        prev_branch = branch;
    endtask

    initial begin
        //  init br tgt  st hi rs | br tgt  ha fl rn cnt
        add(1, 0, 0,   0, 0, 0,   0, 0,   1, 0, 0, 0);   // reset
        add(1, 0, 0,   0, 0, 0,   0, 0,   1, 0, 0, 0);
        add(0, 0, 0,   0, 0, 0,   0, 0,   0, 0, 1, 0);   // IDLE -> RUN
        add(0, 1, 20,  0, 0, 0,   1, 20,  0, 1, 1, 1);   // branch in RUN
        add(0, 0, 0,   0, 0, 0,   0, 20,  0, 1, 1, 1);
        add(0, 0, 0,   0, 0, 0,   0, 20,  0, 0, 1, 1);
        add(0, 0, 0,   0, 0, 0,   0, 20,  0, 0, 1, 1);
        add(0, 0, 0,   1, 0, 0,   0, 20,  1, 0, 0, 1);   // stall, two pending targets
        add(0, 1, 5,   1, 0, 0,   0, 20,  1, 0, 0, 1);
        add(0, 1, 9,   1, 0, 0,   0, 20,  1, 0, 0, 1);
        add(0, 0, 0,   0, 0, 0,   1, 9,   0, 1, 1, 2);   // release issues latest
        add(0, 0, 0,   0, 0, 0,   0, 9,   0, 1, 1, 2);
        add(0, 0, 0,   0, 0, 0,   0, 9,   0, 0, 1, 2);
        add(0, 1, 30,  0, 0, 0,   1, 30,  0, 1, 1, 3);   // flush edge cases
        add(0, 1, 40,  0, 1, 0,   0, 30,  0, 1, 1, 3);   // ignored in FLUSH
        add(0, 0, 0,   1, 0, 0,   0, 30,  1, 1, 1, 3);   // frozen for 3 cycles
        add(0, 0, 0,   1, 0, 0,   0, 30,  1, 1, 1, 3);
        add(0, 0, 0,   1, 0, 0,   0, 30,  1, 1, 1, 3);
        add(0, 0, 0,   0, 0, 0,   0, 30,  0, 0, 1, 3);
        add(0, 1, 50,  0, 1, 0,   0, 30,  1, 0, 0, 3);   // halt beats branch
        add(0, 1, 60,  1, 0, 0,   0, 30,  1, 0, 0, 3);   // ignored in HALTED
        add(0, 0, 0,   0, 0, 1,   0, 30,  0, 0, 1, 3);   // resume
        add(0, 0, 0,   1, 0, 0,   0, 30,  1, 0, 0, 3);   // halt drops pending
        add(0, 1, 70,  1, 0, 0,   0, 30,  1, 0, 0, 3);
        add(0, 0, 0,   1, 1, 0,   0, 30,  1, 0, 0, 3);
        add(0, 0, 0,   0, 0, 1,   0, 30,  0, 0, 1, 3);
        add(0, 0, 0,   1, 0, 0,   0, 30,  1, 0, 0, 3);
        add(0, 0, 0,   0, 0, 0,   0, 30,  0, 0, 1, 3);
        add(0, 0, 0,   1, 0, 0,   0, 30,  1, 0, 0, 3);   // BrReq on release cycle
        add(0, 1, 80,  1, 0, 0,   0, 30,  1, 0, 0, 3);
        add(0, 1, 90,  0, 0, 0,   1, 90,  0, 1, 1, 4);
        add(0, 0, 0,   0, 0, 0,   0, 90,  0, 1, 1, 4);
        add(0, 0, 0,   0, 0, 0,   0, 90,  0, 0, 1, 4);
        add(0, 0, 0,   1, 0, 0,   0, 90,  1, 0, 0, 4);
        add(0, 0, 0,   0, 0, 0,   0, 90,  0, 0, 1, 4);
        add(0, 1, 100, 1, 0, 0,   1, 100, 0, 1, 1, 5);   // branch beats stall
        add(0, 0, 0,   0, 0, 0,   0, 100, 0, 1, 1, 5);
        add(0, 0, 0,   0, 0, 0,   0, 100, 0, 0, 1, 5);
        add(0, 1, 110, 0, 0, 0,   1, 110, 0, 1, 1, 6);   // init mid-flush
        add(1, 0, 0,   0, 0, 0,   0, 0,   1, 0, 0, 0);
        add(0, 0, 0,   0, 0, 0,   0, 0,   0, 0, 1, 0);
        add(0, 0, 0,   1, 0, 0,   0, 0,   1, 0, 0, 0);   // init mid-stall
        add(0, 1, 120, 1, 0, 0,   0, 0,   1, 0, 0, 0);
        add(1, 0, 0,   1, 0, 0,   0, 0,   1, 0, 0, 0);
        add(0, 1, 5,   0, 0, 0,   0, 0,   0, 0, 1, 0);   // IDLE ignores BrReq
        add(0, 0, 0,   1, 0, 0,   0, 0,   1, 0, 0, 0);
        add(0, 0, 0,   0, 0, 0,   0, 0,   0, 0, 1, 0);   // no stale pending

        for (int k = 0; k < vecs.size(); k++) begin
            step(vecs[k].init, vecs[k].br, vecs[k].tgt, vecs[k].stall, vecs[k].hi, vecs[k].res);
            checks++;
            if ({branch, target, halt, flush, running, bcount} !==
                {vecs[k].e_br, vecs[k].e_tgt, vecs[k].e_halt, vecs[k].e_flush, vecs[k].e_run, vecs[k].e_cnt}) begin
                errors++;
                $display("FAIL vec%0d: got br=%0b tgt=%0d halt=%0b flush=%0b run=%0b cnt=%0d, required br=%0b tgt=%0d halt=%0b flush=%0b run=%0b cnt=%0d",
                         k, branch, target, halt, flush, running, bcount,
                         vecs[k].e_br, vecs[k].e_tgt, vecs[k].e_halt, vecs[k].e_flush, vecs[k].e_run, vecs[k].e_cnt);
            end
        end

        // Saturation: 300 branches, each needing three cycles to return to RUN.
        for (int n = 0; n < 300; n++) begin
            logic [7:0] t;
            int         exp_cnt;
            t       = 8'(n);
            exp_cnt = (n + 1 > 255) ? 255 : n + 1;
            step(0, 1, t, 0, 0, 0);
            checks++;
            if (!branch || target !== t || int'(bcount) != exp_cnt) begin
                errors++;
                $display("FAIL sat%0d: got br=%0b tgt=%0d cnt=%0d, required br=1 tgt=%0d cnt=%0d",
                         n, branch, target, bcount, t, exp_cnt);
            end
            step(0, 0, 0, 0, 0, 0);
            step(0, 0, 0, 0, 0, 0);
        end
        checks++;
        if (bcount !== 8'd255 || !running || flush) begin
            errors++;
            $display("FAIL sat_final: got cnt=%0d run=%0b flush=%0b, required cnt=255 run=1 flush=0",
                     bcount, running, flush);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
